// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit in front of a word-only data memory.
// Turns core byte/halfword/word accesses into 32-bit word accesses.
// Sub-word stores are read-modify-write. Loads are lane-extracted and
// sign- or zero-extended.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses complete at once with ERR=1,
//               without touching memory or RDATA
//   undefined : no ERR port; misaligned low address bits are ignored
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   REQ, WE_IN, SIZE  request, store/load select, funct3 size code
//   ADDR, WDATA       byte address and store data
//   RDATA             extended load result, held until the next load
//   BUSY, DONE, ERR   status outputs (ERR only with MISALIGN_TRAP_EN)
//   MEM_A, MEM_WD     word-aligned address and write data to memory
//   MEM_WE, MEM_RD    write enable to memory, read data from memory
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for REQ
//   ACCESS | memory read (load / RMW read) or word write
//   WRITE  | write-back of the merged word for SB/SH
//   FINISH | DONE pulse, then back to IDLE
module lsu_mem_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RDATA_RST = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE_IN,
    input  logic [2:0]        SIZE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              BUSY,
    output logic              DONE,
`ifdef MISALIGN_TRAP_EN
    output logic              ERR,
`endif
    output logic [ADDR_W-1:0] MEM_A,
    output logic [31:0]       MEM_WD,
    output logic              MEM_WE,
    input  logic [31:0]       MEM_RD
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, FINISH} state_t;

    state_t      state;
    logic        we_l;
    logic [2:0]  size_l;
    logic [1:0]  lane;
    logic [31:0] wdata_l;
    logic        mem_we_q;

    logic        is_byte;
    logic        is_half;
    logic [4:0]  sh;
    logic [31:0] rd_shift;
    logic [31:0] mask;
    logic [31:0] load_val;
    logic [31:0] merge_val;
    logic        misalign;

    // SIZE[1] set covers LW/SW and the reserved codes 011/110/111.
    assign is_byte = ~size_l[1] & ~size_l[0];
    assign is_half = ~size_l[1] &  size_l[0];

    // A reset arriving mid-write must keep the pending write off the memory
    // edge, so the registered enable is gated by RST directly.
    assign MEM_WE = mem_we_q & ~RST;

    always_comb begin
        sh        = 5'd0;
        if (is_byte)
            sh = {lane, 3'b000};
        else if (is_half)
            sh = {lane[1], 4'b0000};
        rd_shift  = MEM_RD >> sh;
        mask      = (is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merge_val = (MEM_RD & ~mask) | ((wdata_l << sh) & mask);
        load_val  = MEM_RD;
        if (is_byte)
            load_val = {{24{~size_l[2] & rd_shift[7]}}, rd_shift[7:0]};
        else if (is_half)
            load_val = {{16{~size_l[2] & rd_shift[15]}}, rd_shift[15:0]};
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = (~SIZE[1] & SIZE[0] & ADDR[0]) |
                      (SIZE[1] & (ADDR[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            RDATA    <= RDATA_RST;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            mem_we_q <= 1'b0;
            MEM_WD   <= 32'h0;
            MEM_A    <= '0;
            we_l     <= 1'b0;
            size_l   <= 3'b000;
            lane     <= 2'b00;
            wdata_l  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            ERR      <= 1'b0;
`endif
        end else begin
            DONE     <= 1'b0;
            mem_we_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            ERR      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (REQ) begin
                        we_l    <= WE_IN;
                        size_l  <= SIZE;
                        lane    <= ADDR[1:0];
                        wdata_l <= WDATA;
                        MEM_A   <= {ADDR[ADDR_W-1:2], 2'b00};
                        if (misalign) begin
                            state <= FINISH;
                            DONE  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                            ERR   <= 1'b1;
`endif
                        end else begin
                            state <= ACCESS;
                            BUSY  <= 1'b1;
                            // Word store writes during ACCESS itself.
                            if (WE_IN && SIZE[1]) begin
                                mem_we_q <= 1'b1;
                                MEM_WD   <= WDATA;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (we_l && !size_l[1]) begin
                        MEM_WD   <= merge_val;
                        mem_we_q <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        if (!we_l)
                            RDATA <= load_val;
                        state <= FINISH;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end
                end
                WRITE: begin
                    state <= FINISH;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
